sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Single-clock synchronous FIFO, parametrised in data width and depth (2**ADDR_WIDTH).
//  Provides full/empty, programmable almost-full/almost-empty, occupancy count,
//  sticky overflow/underflow error flags and a synchronous flush.
//  General-purpose buffer between producer/consumer stages in the same clk domain.
// PARAMETERS
//  DATA_WIDTH     8   width of write_data/read_data
//  ADDR_WIDTH     2   log2 of depth; DEPTH = 2**ADDR_WIDTH (legal 1..12)
//  AFULL_THRESH   3   almost_full asserted when count >= AFULL_THRESH (1..DEPTH)
//  AEMPTY_THRESH  1   almost_empty asserted when count <= AEMPTY_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1             clock, rising edge
//  rst           in   1             reset, asynchronous, active-low
//  flush         in   1             synchronous clear of FIFO contents
//  clr_err       in   1             synchronous clear of overflow/underflow
//  push          in   1             write request
//  write_data    in   DATA_WIDTH    write payload
//  pop           in   1             read request
//  read_data     out  DATA_WIDTH    read payload
//  read_valid    out  1             read_data valid (meaning per CONFIGURATION)
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AFULL_THRESH
//  almost_empty  out  1             count <= AEMPTY_THRESH
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: push seen while full
//  underflow     out  1             sticky: pop seen while empty
// BEHAVIOUR
//  - Reset: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0,
//    read_data=0, read_valid=0, overflow=0, underflow=0. Memory not reset.
//  - Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; index = low ADDR_WIDTH bits;
//    natural wrap at DEPTH. full = (MSBs differ, rest equal); empty = (equal).
//  - push accepted iff push && !full; pop accepted iff pop && !empty. Flags sampled
//    pre-edge; no pass-through (push into full is rejected even with pop same cycle).
//  - Accepted push: mem[wr_idx] <= write_data; wr_ptr++. Accepted pop: rd_ptr++.
//  - Both accepted same cycle: count unchanged, both pointers advance.
//  - push && full: data dropped, overflow <= 1. pop && empty: underflow <= 1,
//    read_data holds, read_valid=0 next cycle.
//  - All status outputs (full, empty, almost_*, count) are registered, updated on the
//    same edge as the pointers; they reflect post-edge occupancy, no extra latency.
//  - flush (priority over push/pop): pointers=0, count=0, empty=1, full=0, almost flags
//    per thresholds, read_valid=0; accesses in the flush cycle are ignored and do not
//    set error flags. overflow/underflow unaffected by flush.
//  - clr_err clears both error flags; a new error in the same cycle wins (flag = 1).
//  - Async reset mid-operation: all state returns to reset values immediately.
// CONFIGURATION
//  Macro SYNC_FIFO_FWFT_EN:
//  - Undefined (standard mode): accepted pop registers mem[rd_idx] into read_data;
//    read_valid pulses 1 for exactly the cycle after each accepted pop. Latency 1.
//  - Defined (first-word-fall-through): read_data = mem[rd_idx] combinationally,
//    read_valid = !empty; pop acknowledges the shown word. Write-to-read_valid
//    latency 1 cycle (empty deasserts on the edge after the push). read_data has no
//    reset value (undefined while empty).
// TESTING
//  - Reset, DEPTH=4: push A1,A2,A3,A4 -> full=1 after 4th edge, count=4, almost_full
//    from 3rd; pops return A1..A4 in order, empty=1, count=0.
//  - Full + push 0x55 -> overflow=1, count stays 4, data lost; clr_err -> overflow=0.
//  - Empty + pop -> underflow=1, read_valid=0, read_data unchanged.
//  - count=2, push+pop same cycle for 10 cycles -> count=2 throughout, pointers wrap
//    past index 3, data order preserved.
//  - count=3, flush with push=1 -> count=0, empty=1, overflow/underflow unchanged.
//  - FWFT build: push 0xA5 into empty -> next cycle read_valid=1, read_data=0xA5
//    without pop; standard build: pop -> read_data=0xA5, read_valid pulse 1 cycle later.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Bus bundle for sync_fifo_param: write/read handshake, control and status.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  flush;
    logic                  clr_err;
    logic                  push;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, clr_err, push, write_data, pop,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, push, write_data, pop,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock synchronous FIFO with registered status, sticky error flags
// and synchronous flush. Depth is 2**ADDR_WIDTH.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise
// read_data is registered one cycle after an accepted pop.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 2,
    parameter int AFULL_THRESH  = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                push_ok, pop_ok;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

    // Accept decisions, next pointers, next status and sticky error flags.
    always_comb begin
        push_ok     = bus.push && !full_q && !bus.flush;
        pop_ok      = bus.pop && !empty_q && !bus.flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                   (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
        afull_d  = (count_d >= AFULL_LVL);
        aempty_d = (count_d <= AEMPTY_LVL);

        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!bus.flush && bus.push && full_q) begin
            overflow_d = 1'b1;
        end
        if (!bus.flush && bus.pop && empty_q) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer, status and error-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= bus.write_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.read_data  = mem[rd_idx];
    assign bus.read_valid = !empty_q;
`else
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;

    // Capture the head word on an accepted pop; otherwise hold the last word.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = pop_ok;
        if (pop_ok) begin
            read_data_d = mem[rd_idx];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
